axis_input_controller: RTL and testbench
========================================

// Module: axis_input_controller
// PURPOSE
//  AXI4-Stream slave that receives one frame of CODE_LENGTH channel LLRs.
//  Writes them sequentially into the decoder input-buffer BRAM (address 0..CODE_LENGTH-1).
//  Signals the top-level decoder FSM when the frame is complete.
//  Mirror of the output-side stream master: sits between the DMA/stream source and the input BRAM.
// PARAMETERS
//  CODE_LENGTH    1024    LLR samples per frame
//  ADDR_WIDTH     10      input BRAM address width; 2**ADDR_WIDTH >= CODE_LENGTH
//  DATA_WIDTH     8       LLR width (two's complement), equal to the BRAM data width
//  STATE_WIDTH    10      width of the top-level state bus
//  INPUT_STATE    10'd1   top-level state code in which reception is allowed
//  COUNTER_WIDTH  11      beat counter width; must hold CODE_LENGTH
// PORTS
//  clk                    in   1              clock
//  reset                  in   1              asynchronous, active-high
//  state                  in   STATE_WIDTH    top-level decoder state
//  saxis_tdata            in   DATA_WIDTH     LLR sample
//  saxis_tvalid           in   1              source data valid
//  saxis_tlast            in   1              source end-of-frame marker
//  saxis_tready           out  1              block ready to accept a beat
//  addr_to_input_bram     out  ADDR_WIDTH     BRAM write address
//  data_to_input_bram     out  DATA_WIDTH     BRAM write data
//  we_to_input_bram       out  1              BRAM write enable
//  input_done             out  1              1-cycle pulse: frame fully written
//  frame_error            out  1              sticky tlast mismatch flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: internal FSM=IDLE, counter=0. All registered outputs are 0: addr, data, we, input_done, frame_error.
//  - FSM IDLE:
//      state==INPUT_STATE -> RECV next cycle (counter=0, frame_error cleared).
//  - FSM RECV:
//      saxis_tready = (fsm==RECV) && (state==INPUT_STATE). Combinational from registered FSM and the state input.
//      Beat = saxis_tvalid & saxis_tready.
//      On a beat: counter+1. Registered BRAM outputs next cycle: we=1, addr=counter[ADDR_WIDTH-1:0], data=tdata.
//      No beat: we=0; addr/data hold.
//      A beat at counter==CODE_LENGTH-1 -> DONE. tready is 0 from the next cycle.
//  - FSM DONE:
//      input_done=1 for exactly one cycle. This is 2 cycles after the last beat, i.e. after the last BRAM write commits.
//      Then WAIT.
//  - FSM WAIT:
//      Hold until state!=INPUT_STATE, then IDLE.
//      No re-entry into RECV without leaving INPUT_STATE first.
//  - tvalid may drop/rise freely. Throughput is 1 beat/clk with tvalid held high.
//  - state leaves INPUT_STATE during RECV (abort):
//      tready drops the same cycle; no further writes.
//      FSM -> IDLE, counter cleared, input_done not asserted.
//      A write already registered still completes.
//  - Counter never exceeds CODE_LENGTH. Beats beyond the frame are not accepted (tready=0).
// CONFIGURATION
//  Macro INPUT_TLAST_CHECK_EN.
//  - Defined: frame_error is set (sticky) when either:
//      - tlast=1 on a beat with counter!=CODE_LENGTH-1, or
//      - tlast=0 on the beat with counter==CODE_LENGTH-1.
//    frame_error is cleared only on IDLE->RECV or reset.
//    Early tlast does not end the frame: reception continues to CODE_LENGTH beats.
//  - Undefined: saxis_tlast is ignored; frame_error is tied to 0.
//  - Data path and timing are identical in both builds.
// TESTING
//  1. state=INPUT_STATE, 1024 beats tdata=i[7:0] back-to-back, tlast on beat 1023:
//     -> BRAM addr i holds i[7:0]; input_done single pulse 2 cycles after beat 1023; frame_error=0.
//  2. Same frame with tvalid toggling 1/0 every cycle:
//     -> 1024 writes in order, no duplicate/skipped addresses; input_done once.
//  3. Abort: state leaves INPUT_STATE after 300 beats, then re-enters; send 1024 beats:
//     -> no input_done for the aborted frame; the new frame writes from addr 0; input_done once.
//  4. After DONE, keep state=INPUT_STATE and tvalid=1 for 50 cycles:
//     -> tready=0, we=0, no second input_done.
//  5. INPUT_TLAST_CHECK_EN, tlast on beat 511 and none on beat 1023:
//     -> frame_error=1 from the cycle after beat 511, stays 1; all 1024 beats written.
//     Without the macro: frame_error=0.
//  6. Assert reset mid-frame (beat 700):
//     -> all outputs 0 immediately, FSM IDLE; the next frame starts at addr 0.

Source files
------------

// File: rtl/axis_input_controller.sv
// AXI4-Stream slave that receives one frame of CODE_LENGTH LLRs and writes
// them sequentially into the decoder input BRAM, then pulses input_done.
// Optional build macro: INPUT_TLAST_CHECK_EN (sticky tlast-mismatch flag).
module axis_input_controller #(
    parameter int unsigned CODE_LENGTH   = 1024,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned STATE_WIDTH   = 10,
    parameter logic [STATE_WIDTH-1:0] INPUT_STATE = STATE_WIDTH'(1),
    parameter int unsigned COUNTER_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [STATE_WIDTH-1:0] state,
    input  logic [DATA_WIDTH-1:0]  saxis_tdata,
    input  logic                   saxis_tvalid,
    input  logic                   saxis_tlast,
    output logic                   saxis_tready,
    output logic [ADDR_WIDTH-1:0]  addr_to_input_bram,
    output logic [DATA_WIDTH-1:0]  data_to_input_bram,
    output logic                   we_to_input_bram,
    output logic                   input_done,
    output logic                   frame_error
);

    localparam logic [COUNTER_WIDTH-1:0] LAST_BEAT = COUNTER_WIDTH'(CODE_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DONE,
        S_WAIT
    } fsm_t;

    fsm_t                     fsm, fsm_next;
    logic [COUNTER_WIDTH-1:0] counter, counter_next;
    logic [ADDR_WIDTH-1:0]    addr_next;
    logic [DATA_WIDTH-1:0]    data_next;
    logic                     we_next;
    logic                     done_next;
    logic                     in_state_c;
    logic                     beat_c;
    logic                     last_c;

    assign in_state_c   = (state == INPUT_STATE);
    assign saxis_tready = (fsm == S_RECV) && in_state_c;
    assign beat_c       = saxis_tvalid && saxis_tready;
    assign last_c       = (counter == LAST_BEAT);

    // Next-state, beat counter and BRAM write-port decode
    always_comb begin
        fsm_next     = fsm;
        counter_next = counter;
        addr_next    = addr_to_input_bram;
        data_next    = data_to_input_bram;
        we_next      = 1'b0;
        done_next    = 1'b0;
        unique case (fsm)
            S_IDLE: begin
                if (in_state_c) begin
                    fsm_next     = S_RECV;
                    counter_next = '0;
                end
            end
            S_RECV: begin
                if (!in_state_c) begin
                    fsm_next     = S_IDLE;
                    counter_next = '0;
                end else if (beat_c) begin
                    counter_next = counter + COUNTER_WIDTH'(1);
                    we_next      = 1'b1;
                    addr_next    = counter[ADDR_WIDTH-1:0];
                    data_next    = saxis_tdata;
                    if (last_c) begin
                        fsm_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_next = 1'b1;
                fsm_next  = S_WAIT;
            end
            S_WAIT: begin
                if (!in_state_c) begin
                    fsm_next = S_IDLE;
                end
            end
            default: fsm_next = S_IDLE;
        endcase
    end

    // State, counter and registered BRAM/handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm                <= S_IDLE;
            counter            <= '0;
            addr_to_input_bram <= '0;
            data_to_input_bram <= '0;
            we_to_input_bram   <= 1'b0;
            input_done         <= 1'b0;
        end else begin
            fsm                <= fsm_next;
            counter            <= counter_next;
            addr_to_input_bram <= addr_next;
            data_to_input_bram <= data_next;
            we_to_input_bram   <= we_next;
            input_done         <= done_next;
        end
    end

`ifdef INPUT_TLAST_CHECK_EN
    logic ferr_next;

    // Sticky flag: tlast must appear on exactly the final beat of the frame
    always_comb begin
        ferr_next = frame_error;
        if (fsm == S_IDLE && in_state_c) begin
            ferr_next = 1'b0;
        end else if (beat_c && (saxis_tlast != last_c)) begin
            ferr_next = 1'b1;
        end
    end

    // Frame error register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_error <= 1'b0;
        end else begin
            frame_error <= ferr_next;
        end
    end
`else
    logic unused_tlast;

    assign unused_tlast = saxis_tlast;
    assign frame_error  = 1'b0;
`endif

endmodule

// File: tb/tb_axis_input_controller.sv
// Randomized self-checking bench for axis_input_controller against a
// frame-level reference model (beat count, pending done, expected memory).
module tb_axis_input_controller;

    localparam int unsigned CL = 1024;
    localparam logic [9:0]  IS = 10'd1;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] state;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;
    logic [9:0] addr;
    logic [7:0] data;
    logic       we;
    logic       done;
    logic       ferr;

    axis_input_controller dut (
        .clk                (clk),
        .reset              (reset),
        .state              (state),
        .saxis_tdata        (tdata),
        .saxis_tvalid       (tvalid),
        .saxis_tlast        (tlast),
        .saxis_tready       (tready),
        .addr_to_input_bram (addr),
        .data_to_input_bram (data),
        .we_to_input_bram   (we),
        .input_done         (done),
        .frame_error        (ferr)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: is a frame being accepted, how many beats so far,
    // must the source leave INPUT_STATE before the next frame, and when done is due.
    bit         m_open;
    bit         m_locked;
    int         m_age;
    int         m_beats;
    int         done_in;
    bit         last_beat;
    logic       e_we;
    logic       e_ferr;
    logic [9:0] e_addr;
    logic [7:0] e_data;
    logic [7:0] mem_exp [CL];
    logic [7:0] shadow  [CL];

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open   = 1'b0;
        m_locked = 1'b0;
        m_age    = 0;
        m_beats  = 0;
        done_in  = 0;
        e_we     = 1'b0;
        e_ferr   = 1'b0;
        e_addr   = '0;
        e_data   = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    we,    0);
        check({tag, "_addr"},  addr,  0);
        check({tag, "_data"},  data,  0);
        check({tag, "_done"},  done,  0);
        check({tag, "_ferr"},  ferr,  0);
        check({tag, "_ready"}, tready, 0);
    endtask

    // One clock cycle: drive inputs, predict handshake, advance model, check outputs
    task automatic step(input logic [9:0] st, input logic v, input logic [7:0] d, input logic l);
        bit is_in;
        bit exp_rdy;
        bit beat;
        state  = st;
        tvalid = v;
        tdata  = d;
        tlast  = l;
        #1;
        is_in   = (st == IS);
        exp_rdy = m_open && is_in;
        check("tready", tready, exp_rdy);
        beat      = exp_rdy && v;
        last_beat = beat;
        e_we      = beat;
        if (beat) begin
            e_addr           = 10'(m_beats);
            e_data           = d;
            mem_exp[m_beats] = d;
            if (m_beats == CL - 1) done_in = 2;
        end
        if (!m_open && !m_locked && is_in) e_ferr = 1'b0;
`ifdef INPUT_TLAST_CHECK_EN
        if (beat && (l != (m_beats == CL - 1))) e_ferr = 1'b1;
`endif
        if (m_open) begin
            if (!is_in) begin
                m_open  = 1'b0;
                m_beats = 0;
            end else if (beat) begin
                m_beats++;
                if (m_beats == CL) begin
                    m_open   = 1'b0;
                    m_locked = 1'b1;
                    m_age    = 0;
                end
            end
        end else if (m_locked) begin
            if (!is_in && m_age >= 1) m_locked = 1'b0;
            m_age++;
        end else if (is_in) begin
            m_open  = 1'b1;
            m_beats = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check("we", we, e_we);
        check("addr", addr, e_addr);
        check("data", data, e_data);
        check("frame_error", ferr, e_ferr);
        if (done_in > 0) begin
            done_in--;
            check("input_done", done, done_in == 0);
        end else begin
            check("input_done", done, 0);
        end
        if (we) shadow[addr] = data;
    endtask

    task automatic hold(input logic [9:0] st, input logic v, input int n);
        for (int i = 0; i < n; i++) step(st, v, 8'($urandom), 1'b0);
    endtask

    // Offer n beats; mode 0 = tvalid high, 1 = toggling, 2 = random
    task automatic send_frame(input int n, input int mode, input int tlast_pos, input bit seq_data);
        int   sent  = 0;
        int   guard = 0;
        logic v;
        logic [7:0] d;
        while (sent < n && guard < 6000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = guard[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = seq_data ? 8'(m_beats) : 8'($urandom);
            step(IS, v, d, 1'(m_beats == tlast_pos));
            if (last_beat) sent++;
            guard++;
        end
        check("frame_beats", sent, n);
    endtask

    task automatic check_bram();
        int bad = 0;
        for (int i = 0; i < CL; i++) begin
            if (shadow[i] !== mem_exp[i]) bad++;
        end
        check("bram_contents", bad, 0);
    endtask

    initial begin
        reset  = 1'b1;
        state  = '0;
        tdata  = '0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        model_reset();
        for (int i = 0; i < CL; i++) begin
            shadow[i]  = 8'hxx;
            mem_exp[i] = 8'h00;
        end
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Back-to-back frame with incrementing data, then linger in INPUT_STATE
        send_frame(CL, 0, CL - 1, 1'b1);
        hold(IS, 1'b1, 50);
        check_bram();
        hold(10'd0, 1'b0, 3);

        // tvalid toggling every cycle
        send_frame(CL, 1, CL - 1, 1'b0);
        hold(IS, 1'b0, 4);
        check_bram();
        hold(10'd0, 1'b0, 3);

        // Abort after 300 beats, then a full frame with random tvalid
        send_frame(300, 2, CL - 1, 1'b0);
        hold(10'd0, 1'b1, 3);
        send_frame(CL, 2, CL - 1, 1'b0);
        hold(IS, 1'b0, 4);
        check_bram();
        hold(10'd0, 1'b0, 3);

        // Misplaced tlast: early on beat 511, missing on beat 1023
        send_frame(CL, 2, 511, 1'b0);
        hold(IS, 1'b0, 4);
        check_bram();
        hold(10'd0, 1'b0, 3);

        // Reset in the middle of a frame, then a full frame
        send_frame(700, 0, CL - 1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        send_frame(CL, 2, CL - 1, 1'b0);
        hold(IS, 1'b0, 4);
        check_bram();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
